// File: rtl/feature_rx_pkg.sv
// Shared constants and FSM encodings for the I2C feature-frame receiver.
package feature_rx_pkg;

    localparam int DEFAULT_N_ELEM = 26;
    localparam int DEFAULT_ELEM_W = 8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE     = 3'd0;
    localparam rx_state_t ST_ADDR     = 3'd1;
    localparam rx_state_t ST_ADDR_ACK = 3'd2;
    localparam rx_state_t ST_DATA     = 3'd3;
    localparam rx_state_t ST_DATA_ACK = 3'd4;
    localparam rx_state_t ST_IGNORE   = 3'd5;

    function automatic int bytes_per_frame(input int n_elem, input int elem_w);
        return n_elem * (elem_w / 8);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the raw scl/sda pins and produces one-cycle scl edge and START/STOP pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START/STOP require scl stable high for two samples so they can never coincide with an scl edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            rise_q     <= scl_s & ~scl_prev_q;
            fall_q     <= ~scl_s & scl_prev_q;
            start_q    <= scl_s & scl_prev_q & ~sda_s & sda_prev_q;
            stop_q     <= scl_s & scl_prev_q & sda_s & ~sda_prev_q;
        end
    end

    // sda_prev_q holds the level that was seen at the edge the pulses refer to.
    assign sda_o      = sda_prev_q;
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/feature_vector_i2c_rx.sv
// Write-only I2C slave that assembles feature frames into a double-buffered signed element array.
module feature_vector_i2c_rx
    import feature_rx_pkg::*;
#(
    parameter int         N_ELEM      = DEFAULT_N_ELEM,
    parameter int         ELEM_W      = DEFAULT_ELEM_W,
    parameter logic [6:0] I2C_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    inout  wire                      sda,
    inout  wire                      scl,
    output logic signed [ELEM_W-1:0] feature_vector [N_ELEM],
    output logic                     vector_valid,
    output logic                     frame_error
);

    localparam int         BPE     = ELEM_W / 8;
    localparam int         BPF     = bytes_per_frame(N_ELEM, ELEM_W);
    localparam int         BC_W    = (BPF > 1) ? $clog2(BPF) : 1;
    localparam logic [7:0] ADDR_WR = {I2C_ADDR, 1'b0};

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl),
        .sda_i     (sda),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_det),
        .stop_o    (stop_det)
    );

    rx_state_t               state_q, state_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [6:0]              shift_q, shift_d;
    logic                    ack_q, ack_d;
    logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]              stage_q [BPF];
    logic signed [ELEM_W-1:0] fv_q [N_ELEM];
    logic                    valid_q;
    logic                    ferr_q;

    logic [7:0]              rx_byte;
    logic                    byte_wr;
    logic                    frame_done;
    logic                    trunc;
    logic [7:0]              byte_view [BPF];
    logic signed [ELEM_W-1:0] elem_next [N_ELEM];

    assign rx_byte = {shift_q, sda_s};

    // The final byte bypasses the staging buffer so the frame lands in the output one clk after its last bit.
    generate
        for (genvar gi = 0; gi < BPF; gi++) begin : g_view
            if (gi == BPF - 1) begin : g_last
                assign byte_view[gi] = rx_byte;
            end else begin : g_stage
                assign byte_view[gi] = stage_q[gi];
            end
        end
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
            if (BPE == 1) begin : g_b1
                assign elem_next[gi] = byte_view[gi];
            end else begin : g_b2
                assign elem_next[gi] = {byte_view[BPE*gi], byte_view[BPE*gi+1]};
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ack_d      = ack_q;
        byte_cnt_d = byte_cnt_q;
        byte_wr    = 1'b0;
        frame_done = 1'b0;
        trunc      = 1'b0;
        if (start_det || stop_det) begin
            // A STOP or repeated START always follows one scl rise of its own, so one sampled bit is not a partial byte.
            trunc = (byte_cnt_q != '0) || ((state_q == ST_DATA) && (bit_cnt_q > 3'd1));
            if (trunc) begin
                byte_cnt_d = '0;
            end
            ack_d     = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = start_det ? ST_ADDR : ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            state_d   = (rx_byte == ADDR_WR) ? ST_ADDR_ACK : ST_IGNORE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            byte_wr   = 1'b1;
                            state_d   = ST_DATA_ACK;
                            if (byte_cnt_q == BC_W'(BPF - 1)) begin
                                frame_done = 1'b1;
                                byte_cnt_d = '0;
                            end else begin
                                byte_cnt_d = byte_cnt_q + BC_W'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_d = 1'b1;
                        end else begin
                            ack_d   = 1'b0;
                            state_d = ST_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            ack_q      <= 1'b0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            for (int k = 0; k < BPF; k++) begin
                stage_q[k] <= 8'd0;
            end
            for (int k = 0; k < N_ELEM; k++) begin
                fv_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_q      <= ack_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= frame_done;
            ferr_q     <= trunc;
            if (byte_wr) begin
                stage_q[byte_cnt_q] <= rx_byte;
            end
            if (frame_done) begin
                for (int k = 0; k < N_ELEM; k++) begin
                    fv_q[k] <= elem_next[k];
                end
            end
        end
    end

    // Open-drain ACK; gating with rst releases the line in the very cycle reset is applied.
    assign sda = (ack_q && !rst) ? 1'b0 : 1'bz;

    assign feature_vector = fv_q;
    assign vector_valid   = valid_q;
    assign frame_error    = ferr_q;

endmodule

// File: tb/tb_feature_vector_i2c_rx.sv
// Directed bench: an I2C master on a shared bus drives an 8-bit and a 16-bit receiver instance.
module tb_feature_vector_i2c_rx;

    localparam int Q      = 5;
    localparam int P_ZERO = 0;
    localparam int P_RAMP = 1;
    localparam int P_C10  = 2;
    localparam int P_C33  = 3;
    localparam int P_W16  = 4;
    localparam int P_INC  = 5;
    localparam int P_INC2 = 6;
    localparam int NT     = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic scl_drv;
    logic sda_low;
    wire  sda;
    wire  scl;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_drv;

    logic signed [7:0]  fv_a [26];
    logic signed [15:0] fv_b [4];
    logic va, ea, vb, eb;

    feature_vector_i2c_rx dut_a (
        .clk           (clk),
        .rst           (rst),
        .sda           (sda),
        .scl           (scl),
        .feature_vector(fv_a),
        .vector_valid  (va),
        .frame_error   (ea)
    );

    feature_vector_i2c_rx #(
        .N_ELEM  (4),
        .ELEM_W  (16),
        .I2C_ADDR(7'h21)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .sda           (sda),
        .scl           (scl),
        .feature_vector(fv_b),
        .vector_valid  (vb),
        .frame_error   (eb)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_va = 0, cnt_ea = 0, cnt_vb = 0, cnt_eb = 0, n_overlap = 0;
    int s_va, s_ea, s_vb, s_eb;

    always @(negedge clk) begin
        if (va) cnt_va <= cnt_va + 1;
        if (ea) cnt_ea <= cnt_ea + 1;
        if (vb) cnt_vb <= cnt_vb + 1;
        if (eb) cnt_eb <= cnt_eb + 1;
        if ((va && ea) || (vb && eb)) n_overlap <= n_overlap + 1;
    end

    typedef struct {
        logic [7:0] addr_byte;
        int         nbytes;
        int         tx_pat;
        int         exp_acks;
        int         exp_va;
        int         exp_ea;
        int         exp_vb;
        int         exp_eb;
        int         pat_a;
        int         pat_b;
    } txn_t;

    txn_t tbl [NT];

    function automatic logic [7:0] frame_byte(input int pat, input int k);
        logic [7:0] w16 [8];
        w16 = '{8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'hFE};
        case (pat)
            P_RAMP:  return (k < 25) ? 8'(k + 1) : 8'hFF;
            P_C10:   return 8'h10;
            P_C33:   return 8'h33;
            P_W16:   return w16[k % 8];
            P_INC:   return 8'(k);
            P_INC2:  return 8'(8 + k);
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vectors(input string tag, input int pat_a, input int pat_b);
        for (int e = 0; e < 26; e++) begin
            check($sformatf("%s fv_a[%0d]", tag, e), int'(fv_a[e]),
                  int'($signed(frame_byte(pat_a, e))));
        end
        for (int e = 0; e < 4; e++) begin
            check($sformatf("%s fv_b[%0d]", tag, e), int'(fv_b[e]),
                  int'($signed({frame_byte(pat_b, 2 * e), frame_byte(pat_b, 2 * e + 1)})));
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_va = cnt_va;
        s_ea = cnt_ea;
        s_vb = cnt_vb;
        s_eb = cnt_eb;
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        sda_low = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        sda_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        sda_low = ~b;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(2 * Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_low = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        ack = (sda == 1'b0);
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_bytes(input int nbytes, input int pat, inout int acks);
        bit ack;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(frame_byte(pat, i), ack);
            if (ack) acks++;
        end
    endtask

    task automatic run_txn(input logic [7:0] addr, input int nbytes, input int pat, output int acks);
        bit ack;
        acks = 0;
        i2c_start();
        send_byte(addr, ack);
        if (ack) acks++;
        send_bytes(nbytes, pat, acks);
        i2c_stop();
    endtask

    initial begin
        int         acks;
        bit         ack;
        logic [7:0] addr_a;

        addr_a = 8'h84;
        tbl[0] = '{8'h84, 26, P_RAMP, 27, 1, 0, 0, 0, P_RAMP, P_ZERO};
        tbl[1] = '{8'h86, 26, P_C33,   0, 0, 0, 0, 0, P_RAMP, P_ZERO};
        tbl[2] = '{8'h85, 26, P_C33,   0, 0, 0, 0, 0, P_RAMP, P_ZERO};
        tbl[3] = '{8'h84, 10, P_C33,  11, 0, 1, 0, 0, P_RAMP, P_ZERO};
        tbl[4] = '{8'h84, 26, P_C10,  27, 1, 0, 0, 0, P_C10,  P_ZERO};
        tbl[5] = '{8'h42,  8, P_W16,   9, 0, 0, 1, 0, P_C10,  P_W16};
        tbl[6] = '{8'h42, 16, P_INC,  17, 0, 0, 2, 0, P_C10,  P_INC2};

        rst     = 1'b1;
        scl_drv = 1'b1;
        sda_low = 1'b0;
        wait_clks(3);
        check_vectors("reset", P_ZERO, P_ZERO);
        check("reset sda released", int'(sda), 1);
        check("reset no pulses", cnt_va + cnt_ea + cnt_vb + cnt_eb, 0);
        rst = 1'b0;
        wait_clks(5);

        for (int t = 0; t < NT; t++) begin
            snap();
            run_txn(tbl[t].addr_byte, tbl[t].nbytes, tbl[t].tx_pat, acks);
            wait_clks(10);
            $display("txn %0d: addr=%02h bytes=%0d acks=%0d va=%0d ea=%0d vb=%0d eb=%0d",
                     t, tbl[t].addr_byte, tbl[t].nbytes, acks,
                     cnt_va - s_va, cnt_ea - s_ea, cnt_vb - s_vb, cnt_eb - s_eb);
            check($sformatf("txn%0d acks", t), acks, tbl[t].exp_acks);
            check($sformatf("txn%0d valid_a", t), cnt_va - s_va, tbl[t].exp_va);
            check($sformatf("txn%0d error_a", t), cnt_ea - s_ea, tbl[t].exp_ea);
            check($sformatf("txn%0d valid_b", t), cnt_vb - s_vb, tbl[t].exp_vb);
            check($sformatf("txn%0d error_b", t), cnt_eb - s_eb, tbl[t].exp_eb);
            check_vectors($sformatf("txn%0d", t), tbl[t].pat_a, tbl[t].pat_b);
            if (t == 0) begin
                check("ramp fv_a[0]", int'(fv_a[0]), 1);
                check("ramp fv_a[24]", int'(fv_a[24]), 25);
                check("ramp fv_a[25]", int'(fv_a[25]), -1);
            end
            if (t == 5) begin
                check("w16 fv_b[0]", int'(fv_b[0]), -32768);
                check("w16 fv_b[1]", int'(fv_b[1]), 32767);
                check("w16 fv_b[2]", int'(fv_b[2]), 1);
                check("w16 fv_b[3]", int'(fv_b[3]), -2);
            end
        end

        // Reset while the slave is holding the ACK low.
        snap();
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(addr_a[i]);
        sda_low = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        check("ack before reset", int'(sda), 0);
        rst = 1'b1;
        #1;
        check("sda released in reset", int'(sda), 1);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
        i2c_stop();
        check_vectors("after reset", P_ZERO, P_ZERO);
        run_txn(8'h84, 26, P_RAMP, acks);
        wait_clks(10);
        $display("txn reset-at-ack then ramp frame: acks=%0d va=%0d ea=%0d",
                 acks, cnt_va - s_va, cnt_ea - s_ea);
        check("post-reset acks", acks, 27);
        check("post-reset valid_a", cnt_va - s_va, 1);
        check("post-reset error_a", cnt_ea - s_ea, 0);
        check_vectors("post-reset", P_RAMP, P_ZERO);

        // Repeated START after 5 data bytes truncates, then a full frame follows.
        snap();
        acks = 0;
        i2c_start();
        send_byte(addr_a, ack);
        if (ack) acks++;
        send_bytes(5, P_C33, acks);
        i2c_start();
        send_byte(addr_a, ack);
        if (ack) acks++;
        check("rstart error pulse", cnt_ea - s_ea, 1);
        check("rstart fv_a[0] kept", int'(fv_a[0]), 1);
        send_bytes(26, P_C10, acks);
        i2c_stop();
        wait_clks(10);
        $display("txn repeated-start: acks=%0d va=%0d ea=%0d", acks, cnt_va - s_va, cnt_ea - s_ea);
        check("rstart acks", acks, 33);
        check("rstart valid_a", cnt_va - s_va, 1);
        check("rstart error_a", cnt_ea - s_ea, 1);
        check_vectors("rstart", P_C10, P_ZERO);

        // STOP in the middle of the first data byte.
        snap();
        i2c_start();
        send_byte(addr_a, ack);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        i2c_stop();
        wait_clks(10);
        $display("txn partial-byte stop: ack=%0d va=%0d ea=%0d", ack, cnt_va - s_va, cnt_ea - s_ea);
        check("partial addr ack", int'(ack), 1);
        check("partial valid_a", cnt_va - s_va, 0);
        check("partial error_a", cnt_ea - s_ea, 1);
        check_vectors("partial", P_C10, P_ZERO);

        check("valid/error overlap cycles", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
